// File: rtl/aes_host_pkg.sv
// Shared types and helpers for the AES wrapper host driver.
package aes_host_pkg;

    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        WAIT,
        COLLECT,
        HOLD,
        GAP
    } state_t;

    // 32-bit word idx of a 128-bit block, most significant word first.
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_word_serializer.sv
// 128-bit shadow register feeding a registered 32-bit word port.
module aes_word_serializer
    import aes_host_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] blk_in,
    input  logic         shift,
    input  logic [1:0]   idx,
    output logic [31:0]  word
);

    logic [127:0] shadow;

    // Capture the whole block when the request is accepted.
    always_ff @(posedge clk) begin
        if (rst)       shadow <= '0;
        else if (load) shadow <= blk_in;
    end

    // Present the selected word; holds its last value between shifts.
    always_ff @(posedge clk) begin
        if (rst)        word <= '0;
        else if (shift) word <= word_sel(shadow, idx);
    end

endmodule

// File: rtl/aes_block_host_driver.sv
// Host-side driver: serializes one block/key/IV into the AES wrapper and
// gathers the four-word result into a 128-bit valid/ready output.
module aes_block_host_driver
    import aes_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    input  logic [127:0] in_iv,
    input  logic         in_decrypt,
    input  logic         in_cbc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         err_timeout,
    output logic         err_protocol,
    output logic         core_start,
    output logic [31:0]  core_text,
    output logic [31:0]  core_key,
    output logic [31:0]  core_iv,
    output logic         core_decrypt,
    output logic         core_cbc,
    input  logic         core_done,
    input  logic [31:0]  core_text_out
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);

    state_t          state, state_d;
    logic [1:0]      cnt, cnt_d;
    logic [TW-1:0]   timer, timer_d;
    logic [GW-1:0]   gap_cnt, gap_d;
    logic            accept, ser_shift, cap_en, out_load, err_to_d, err_pr_d;
    logic [1:0]      ser_idx;
    logic [127:0]    collect;

    // Index 2 = text, 1 = key, 0 = IV.
    logic [2:0][127:0] ser_din;
    logic [2:0][31:0]  ser_word;

    assign accept  = (state == IDLE) && in_valid && in_ready;
    assign ser_din = {in_text, in_key, in_iv};

    for (genvar g = 0; g < 3; g++) begin : g_ser
        aes_word_serializer u_ser (
            .clk    (clk),
            .rst    (rst),
            .load   (accept),
            .blk_in (ser_din[g]),
            .shift  (ser_shift),
            .idx    (ser_idx),
            .word   (ser_word[g])
        );
    end

    assign core_text = ser_word[2];
    assign core_key  = ser_word[1];
    assign core_iv   = ser_word[0];

    // Next-state, counter and datapath-enable decode.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        timer_d   = timer;
        gap_d     = gap_cnt;
        ser_shift = 1'b0;
        ser_idx   = '0;
        cap_en    = 1'b0;
        out_load  = 1'b0;
        err_to_d  = 1'b0;
        err_pr_d  = 1'b0;
        case (state)
            IDLE: if (accept) state_d = START;
            START: begin
                ser_shift = 1'b1;
                cnt_d     = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (core_done) begin
                    // The wrapper cannot finish before it has every word.
                    err_pr_d = 1'b1;
                    gap_d    = '0;
                    state_d  = GAP;
                end else if (cnt == LAST_WORD) begin
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    ser_shift = 1'b1;
                    ser_idx   = cnt + 2'd1;
                    cnt_d     = cnt + 2'd1;
                end
            end
            WAIT: begin
                if (core_done) begin
                    cap_en  = 1'b1;
                    cnt_d   = 2'd1;
                    state_d = COLLECT;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_to_d = 1'b1;
                    gap_d    = '0;
                    state_d  = GAP;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            COLLECT: begin
                if (!core_done) begin
                    // Burst ended early; the partial result is simply never loaded.
                    err_pr_d = 1'b1;
                    gap_d    = '0;
                    state_d  = GAP;
                end else begin
                    cap_en = 1'b1;
                    if (cnt == LAST_WORD) begin
                        out_load = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        cnt_d = cnt + 2'd1;
                    end
                end
            end
            HOLD: if (out_ready) begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                                gap_d   = gap_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            timer   <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            timer   <= timer_d;
            gap_cnt <= gap_d;
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready     <= 1'b0;
            core_start   <= 1'b0;
            out_valid    <= 1'b0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
            core_decrypt <= 1'b0;
            core_cbc     <= 1'b0;
            collect      <= '0;
            out_text     <= '0;
        end else begin
            in_ready     <= (state_d == IDLE);
            core_start   <= (state_d == START);
            out_valid    <= (state_d == HOLD);
            err_timeout  <= err_to_d;
            err_protocol <= err_pr_d;
            if (accept) begin
                core_decrypt <= in_decrypt;
                core_cbc     <= in_cbc;
            end
            if (cap_en)   collect  <= {collect[95:0], core_text_out};
            if (out_load) out_text <= {collect[95:0], core_text_out};
        end
    end

endmodule

// File: tb/tb_aes_block_host_driver.sv
// Directed + randomized bench for aes_block_host_driver with a behavioural
// stand-in for the serialized AES wrapper.
module tb_aes_block_host_driver;

    localparam int TO  = 16;
    localparam int GAP = 2;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_decrypt, in_cbc;
    logic [127:0] in_text, in_key, in_iv;
    logic         out_valid, out_ready;
    logic [127:0] out_text;
    logic         err_timeout, err_protocol, core_start;
    logic [31:0]  core_text, core_key, core_iv, core_text_out;
    logic         core_decrypt, core_cbc, core_done;

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_to = 0, n_pr = 0, n_ov = 0, to_cyc = -1, pr_cyc = -1;

    // Wrapper model controls and observations
    int           core_lat = 2, core_burst = 4;
    int           start_cyc = -1, done_cyc = -1;
    logic [127:0] cap_text, cap_key, cap_iv, mdl_res;
    logic         cap_dec, cap_cbc;

    aes_block_host_driver #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
        .in_iv(in_iv), .in_decrypt(in_decrypt), .in_cbc(in_cbc),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
        .err_timeout(err_timeout), .err_protocol(err_protocol),
        .core_start(core_start), .core_text(core_text), .core_key(core_key), .core_iv(core_iv),
        .core_decrypt(core_decrypt), .core_cbc(core_cbc),
        .core_done(core_done), .core_text_out(core_text_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Stand-in cipher: the driver only transports words, so a known-answer
    // entry for the FIPS-197 vector plus a cheap mix for everything else is enough.
    function automatic logic [127:0] core_fn(input logic [127:0] t, k, iv, input logic dec, cbc);
        if (t == FIPS_PT && k == FIPS_KEY && !dec && !cbc) return FIPS_CT;
        return {t[63:0], t[127:64]} ^ k ^ (cbc ? iv : 128'h0) ^ {128{dec}};
    endfunction

    // Wrapper model: take four words after start, answer after core_lat with a core_burst-long done.
    initial begin
        core_done     = 1'b0;
        core_text_out = '0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                start_cyc = cyc;
                cap_dec   = core_decrypt;
                cap_cbc   = core_cbc;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    cap_text = {cap_text[95:0], core_text};
                    cap_key  = {cap_key[95:0], core_key};
                    cap_iv   = {cap_iv[95:0], core_iv};
                end
                mdl_res = core_fn(cap_text, cap_key, cap_iv, cap_dec, cap_cbc);
                repeat (core_lat) @(negedge clk);
                for (int k = 0; k < core_burst; k++) begin
                    if (k == 0) done_cyc = cyc;
                    core_done     = 1'b1;
                    core_text_out = mdl_res[127-32*k -: 32];
                    @(negedge clk);
                end
                core_done     = 1'b0;
                core_text_out = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (err_timeout === 1'b1)  begin n_to++; to_cyc = cyc; end
        if (err_protocol === 1'b1) begin n_pr++; pr_cyc = cyc; end
        if (out_valid === 1'b1)    n_ov++;
    endtask

    task automatic clear_mon();
        n_to = 0; n_pr = 0; n_ov = 0; to_cyc = -1; pr_cyc = -1;
    endtask

    // Present a request and return the cycle in which it is accepted.
    task automatic send(input logic [127:0] t, k, iv, input logic dec, cbc, output int acc);
        in_valid = 1'b1; in_text = t; in_key = k; in_iv = iv; in_decrypt = dec; in_cbc = cbc;
        acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            if (in_ready === 1'b1) acc = cyc;
            else step();
        end
        chk("accept_seen", acc >= 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int oc);
        oc = -1;
        for (int i = 0; i < 200 && oc < 0; i++) begin
            if (out_valid === 1'b1) oc = cyc;
            else step();
        end
        chk("out_valid_seen", oc >= 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic xact(input logic [127:0] t, k, iv, input logic dec, cbc,
                        input int lat, input int stall, output logic [127:0] got);
        int acc, oc;
        logic [127:0] exp;
        core_lat = lat; core_burst = 4;
        send(t, k, iv, dec, cbc, acc);
        wait_out(oc);
        exp = core_fn(t, k, iv, dec, cbc);
        got = out_text;
        chk("start_cycle", start_cyc, acc + 1);
        chk("sent_text", cap_text, t);
        chk("sent_key", cap_key, k);
        chk("sent_iv", cap_iv, iv);
        chk("sent_mode", {cap_dec, cap_cbc}, {dec, cbc});
        chk("out_latency", oc, done_cyc + 4);
        chk("out_text", out_text, exp);
        for (int i = 0; i < stall; i++) begin
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_text", out_text, exp);
        end
        drain();
        chk("valid_drop", out_valid, 0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] got, r1, r2, e1, e2;
        int acc, oc, h, rdy;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_text = '0; in_key = '0; in_iv = '0; in_decrypt = 1'b0; in_cbc = 1'b0;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            chk("rst_ctrl", {out_valid, core_start, err_timeout, err_protocol, in_ready, core_decrypt, core_cbc}, 0);
            chk("rst_words", {core_text, core_key, core_iv}, 0);
            chk("rst_out_text", out_text, 0);
        end
        rst = 1'b0;
        step();
        chk("ready_after_rst", in_ready, 1);

        // FIPS-197 ECB encrypt
        xact(FIPS_PT, FIPS_KEY, rnd128(), 1'b0, 1'b0, 3, 0, got);
        chk("fips_ct", got, FIPS_CT);

        // Backpressure with a second request waiting
        r1 = rnd128(); r2 = rnd128();
        e1 = core_fn(r1, FIPS_KEY, r2, 1'b0, 1'b1);
        e2 = core_fn(r2, r1, FIPS_KEY, 1'b1, 1'b1);
        core_lat = 1; core_burst = 4;
        send(r1, FIPS_KEY, r2, 1'b0, 1'b1, acc);
        wait_out(oc);
        chk("bp_first_text", out_text, e1);
        in_valid = 1'b1; in_text = r2; in_key = r1; in_iv = FIPS_KEY; in_decrypt = 1'b1; in_cbc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_text", out_text, e1);
            chk("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1; h = cyc;
        step();
        out_ready = 1'b0;
        send(r2, r1, FIPS_KEY, 1'b1, 1'b1, acc);
        chk("bp_accept_cycle", acc, h + GAP + 1);
        wait_out(oc);
        chk("bp_second_text", out_text, e2);
        drain();

        // Timeout: wrapper never answers
        clear_mon();
        core_burst = 0; core_lat = 1;
        send(rnd128(), rnd128(), rnd128(), 1'b0, 1'b0, acc);
        repeat (22) step();
        chk("to_count", n_to, 1);
        chk("to_cycle", to_cyc, acc + 6 + TO);
        chk("to_no_valid", n_ov, 0);
        chk("to_no_proto", n_pr, 0);
        rdy = -1;
        for (int i = 0; i < 20 && rdy < 0; i++) begin
            if (in_ready === 1'b1) rdy = cyc;
            else step();
        end
        chk("to_ready_back", rdy, to_cyc + GAP);

        // Short done burst
        clear_mon();
        core_burst = 2; core_lat = 2;
        send(rnd128(), rnd128(), rnd128(), 1'b1, 1'b0, acc);
        repeat (20) step();
        chk("short_pr_count", n_pr, 1);
        chk("short_pr_cycle", pr_cyc, done_cyc + 3);
        chk("short_no_valid", n_ov, 0);
        chk("short_no_to", n_to, 0);
        r1 = rnd128();
        xact(r1, rnd128(), rnd128(), 1'b1, 1'b1, 2, 1, got);

        // Reset during SEND word 2, then a stray done burst
        clear_mon();
        core_lat = 3; core_burst = 4;
        send(rnd128(), rnd128(), rnd128(), 1'b0, 1'b1, acc);
        while (cyc < acc + 4) step();
        rst = 1'b1;
        step();
        chk("rst_mid_start", core_start, 0);
        chk("rst_mid_ready", in_ready, 0);
        chk("rst_mid_words", {core_text, core_key, core_iv}, 0);
        rst = 1'b0;
        step();
        chk("rst_mid_idle", in_ready, 1);
        repeat (15) step();
        chk("stray_no_err", n_to + n_pr, 0);
        chk("stray_no_valid", n_ov, 0);
        chk("stray_ready", in_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 8; n++) begin
            xact(rnd128(), rnd128(), rnd128(), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 $urandom_range(1, 6), $urandom_range(0, 3), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
